decode_issue_scheduler: RTL and testbench

Two-thread issue scheduler that sits directly in front of `DecodeUnit`. It buffers fetched instructions per hardware thread in small FIFOs and picks one instruction per cycle with round-robin arbitration. It stamps each instruction with a monotonically increasing major instruction ID and presents it on the decode unit's input bus, honouring the downstream stall.

---
 rtl/decode_issue_scheduler_pkg.sv | 26 ++
 rtl/decode_thread_fifo.sv | 50 +++++
 rtl/decode_issue_scheduler.sv | 155 +++++++++++++++
 tb/tb_decode_issue_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_scheduler_pkg.sv
// Shared types for the two-thread decode issue scheduler: thread indexing,
// default FIFO depth and the per-thread FIFO entry record.
package decode_issue_scheduler_pkg;

    localparam int threadCount             = 2;
    localparam int defaultFifoDepth        = 4;
    localparam int defaultAddressWidth     = 64;
    localparam int defaultInstructionWidth = 32;
    localparam int defaultPidSize          = 20;
    localparam int defaultTidSize          = 16;

    typedef enum logic {
        threadZero = 1'b0,
        threadOne  = 1'b1
    } threadIdx_t;

    // One buffered fetch; field widths follow the scheduler's default parameters.
    typedef struct packed {
        logic [defaultInstructionWidth-1:0] instruction;
        logic [defaultAddressWidth-1:0]     address;
        logic                               is64Bit;
        logic [defaultPidSize-1:0]          pid;
        logic [defaultTidSize-1:0]          tid;
    } fifoEntry_t;

endpackage

// File: rtl/decode_thread_fifo.sv
// Per-thread circular buffer. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate count. Flush empties the buffer
// and wins over a same-cycle push or pop.
module decode_thread_fifo
    import decode_issue_scheduler_pkg::*;
#(
    parameter int depth = defaultFifoDepth
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  fifoEntry_t data_i,
    output fifoEntry_t data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int ptrW = $clog2(depth);

    logic [ptrW:0] wrPtr;
    logic [ptrW:0] rdPtr;
    fifoEntry_t    mem [depth];
    logic          doPush;
    logic          doPop;

    assign full_o  = (wrPtr[ptrW] != rdPtr[ptrW]) && (wrPtr[ptrW-1:0] == rdPtr[ptrW-1:0]);
    assign empty_o = (wrPtr == rdPtr);
    assign data_o  = mem[rdPtr[ptrW-1:0]];
    assign doPush  = push_i && !full_o && !flush_i;
    assign doPop   = pop_i && !empty_o && !flush_i;

    // Pointer update: reset and flush both collapse the buffer to empty.
    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + (ptrW+1)'(1);
            if (doPop)  rdPtr <= rdPtr + (ptrW+1)'(1);
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clock_i) begin
        if (doPush) mem[wrPtr[ptrW-1:0]] <= data_i;
    end

endmodule

// File: rtl/decode_issue_scheduler.sv
// Two-thread round-robin issue scheduler in front of DecodeUnit.
// Optional build macro DECODE_SCHED_PERF_EN adds per-thread issue counters
// and a stalled-valid cycle counter (32-bit, saturating).
module decode_issue_scheduler
    import decode_issue_scheduler_pkg::*;
#(
    parameter int addressWidth            = defaultAddressWidth,
    parameter int instructionWidth        = defaultInstructionWidth,
    parameter int PidSize                 = defaultPidSize,
    parameter int TidSize                 = defaultTidSize,
    parameter int instructionCounterWidth = 64,
    parameter int fifoDepth               = defaultFifoDepth
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               t0Valid_i,
    output logic                               t0Ready_o,
    input  logic [instructionWidth-1:0]        t0Instruction_i,
    input  logic [addressWidth-1:0]            t0Address_i,
    input  logic                               t0Is64Bit_i,
    input  logic [PidSize-1:0]                 t0Pid_i,
    input  logic [TidSize-1:0]                 t0Tid_i,
    input  logic                               t1Valid_i,
    output logic                               t1Ready_o,
    input  logic [instructionWidth-1:0]        t1Instruction_i,
    input  logic [addressWidth-1:0]            t1Address_i,
    input  logic                               t1Is64Bit_i,
    input  logic [PidSize-1:0]                 t1Pid_i,
    input  logic [TidSize-1:0]                 t1Tid_i,
    input  logic [1:0]                         flush_i,
    input  logic                               stall_i,
    output logic                               decEnable_o,
    output logic [instructionWidth-1:0]        decInstruction_o,
    output logic [addressWidth-1:0]            decAddress_o,
    output logic                               decIs64Bit_o,
    output logic [PidSize-1:0]                 decPid_o,
    output logic [TidSize-1:0]                 decTid_o,
    output logic [instructionCounterWidth-1:0] decMajId_o,
`ifdef DECODE_SCHED_PERF_EN
    output logic [31:0]                        t0IssueCount_o,
    output logic [31:0]                        t1IssueCount_o,
    output logic [31:0]                        stallCycles_o,
`endif
    output logic                               decThread_o
);

    logic [threadCount-1:0]             full;
    logic [threadCount-1:0]             empty;
    logic [threadCount-1:0]             push;
    logic [threadCount-1:0]             pop;
    logic [threadCount-1:0]             cand;
    fifoEntry_t                         pushEntry [threadCount];
    fifoEntry_t                         head      [threadCount];
    logic                               issue;
    threadIdx_t                         winner;
    threadIdx_t                         lastThread;
    logic [instructionCounterWidth-1:0] majCounter;

    assign pushEntry[0] = '{instruction: t0Instruction_i, address: t0Address_i,
                            is64Bit: t0Is64Bit_i, pid: t0Pid_i, tid: t0Tid_i};
    assign pushEntry[1] = '{instruction: t1Instruction_i, address: t1Address_i,
                            is64Bit: t1Is64Bit_i, pid: t1Pid_i, tid: t1Tid_i};

    assign push      = {t1Valid_i, t0Valid_i} & ~full;
    assign t0Ready_o = ~full[0];
    assign t1Ready_o = ~full[1];

    for (genvar n = 0; n < threadCount; n++) begin : gThread
        decode_thread_fifo #(.depth(fifoDepth)) uFifo (
            .clock_i (clock_i),
            .reset_i (reset_i),
            .push_i  (push[n]),
            .pop_i   (pop[n]),
            .flush_i (flush_i[n]),
            .data_i  (pushEntry[n]),
            .data_o  (head[n]),
            .full_o  (full[n]),
            .empty_o (empty[n])
        );
    end

    // Round-robin arbitration; a thread being flushed cannot win this cycle.
    always_comb begin
        cand   = ~empty & ~flush_i;
        issue  = !stall_i && (|cand);
        winner = threadZero;
        if (cand[0] && cand[1]) begin
            winner = (lastThread == threadZero) ? threadOne : threadZero;
        end else if (cand[1]) begin
            winner = threadOne;
        end
        pop    = '0;
        pop[0] = issue && (winner == threadZero);
        pop[1] = issue && (winner == threadOne);
    end

    // Output register toward decode: advances only when not stalled; a flush of
    // the held thread drops its valid even under stall.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            decEnable_o      <= 1'b0;
            decInstruction_o <= '0;
            decAddress_o     <= '0;
            decIs64Bit_o     <= 1'b0;
            decPid_o         <= '0;
            decTid_o         <= '0;
            decMajId_o       <= '0;
            decThread_o      <= 1'b0;
        end else if (!stall_i) begin
            decEnable_o <= issue;
            if (issue) begin
                decInstruction_o <= head[winner].instruction;
                decAddress_o     <= head[winner].address;
                decIs64Bit_o     <= head[winner].is64Bit;
                decPid_o         <= head[winner].pid;
                decTid_o         <= head[winner].tid;
                decMajId_o       <= majCounter;
                decThread_o      <= winner;
            end
        end else if (flush_i[decThread_o]) begin
            decEnable_o <= 1'b0;
        end
    end

    // Major ID counter and round-robin pointer; flush never rewinds the counter.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            majCounter <= '0;
            lastThread <= threadOne;
        end else if (issue) begin
            majCounter <= majCounter + instructionCounterWidth'(1);
            lastThread <= winner;
        end
    end

`ifdef DECODE_SCHED_PERF_EN
    function automatic logic [31:0] satInc(input logic [31:0] value);
        return (&value) ? value : value + 32'd1;
    endfunction

    // Performance counters, held at all-ones once saturated.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            t0IssueCount_o <= '0;
            t1IssueCount_o <= '0;
            stallCycles_o  <= '0;
        end else begin
            if (pop[0])                  t0IssueCount_o <= satInc(t0IssueCount_o);
            if (pop[1])                  t1IssueCount_o <= satInc(t1IssueCount_o);
            if (stall_i && decEnable_o)  stallCycles_o  <= satInc(stallCycles_o);
        end
    end
`endif

endmodule

// File: tb/tb_decode_issue_scheduler.sv
// Self-checking bench for decode_issue_scheduler: directed scenarios with
// literal expectations plus randomized traffic against a queue-based model.
module tb_decode_issue_scheduler;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] ins;
        logic [63:0] addr;
        logic        is64;
        logic [19:0] pid;
        logic [15:0] tid;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld   [2];
    logic [31:0] ins   [2];
    logic [63:0] addr  [2];
    logic        is64  [2];
    logic [19:0] pid   [2];
    logic [15:0] tid   [2];
    logic [1:0]  flush;
    logic        stall;

    logic        t0Ready, t1Ready, decEnable, decIs64Bit, decThread;
    logic [31:0] decInstruction;
    logic [63:0] decAddress, decMajId;
    logic [19:0] decPid;
    logic [15:0] decTid;
`ifdef DECODE_SCHED_PERF_EN
    logic [31:0] t0IssueCount, t1IssueCount, stallCycles;
`endif

    int tests = 0;
    int fails = 0;
    bit chkOn = 0;

    always #5 clk = ~clk;

    decode_issue_scheduler dut (
        .clock_i(clk), .reset_i(rst),
        .t0Valid_i(vld[0]), .t0Ready_o(t0Ready), .t0Instruction_i(ins[0]),
        .t0Address_i(addr[0]), .t0Is64Bit_i(is64[0]), .t0Pid_i(pid[0]), .t0Tid_i(tid[0]),
        .t1Valid_i(vld[1]), .t1Ready_o(t1Ready), .t1Instruction_i(ins[1]),
        .t1Address_i(addr[1]), .t1Is64Bit_i(is64[1]), .t1Pid_i(pid[1]), .t1Tid_i(tid[1]),
        .flush_i(flush), .stall_i(stall),
        .decEnable_o(decEnable), .decInstruction_o(decInstruction), .decAddress_o(decAddress),
        .decIs64Bit_o(decIs64Bit), .decPid_o(decPid), .decTid_o(decTid), .decMajId_o(decMajId),
`ifdef DECODE_SCHED_PERF_EN
        .t0IssueCount_o(t0IssueCount), .t1IssueCount_o(t1IssueCount), .stallCycles_o(stallCycles),
`endif
        .decThread_o(decThread)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    ent_t        q [2][$];
    bit          mEn;
    ent_t        mOut;
    logic [63:0] mMaj, mCnt;
    bit          mThr, mLast;
    logic [31:0] mIss [2];
    logic [31:0] mStall;

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    always @(posedge clk) begin
        ent_t inE [2];
        bit   acc [2];
        bit   cand [2];
        int   w;
        if (rst) begin
            q[0].delete(); q[1].delete();
            mEn = 0; mOut = '0; mMaj = '0; mThr = 0; mCnt = '0; mLast = 1;
            mIss[0] = '0; mIss[1] = '0; mStall = '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                inE[n]  = '{ins: ins[n], addr: addr[n], is64: is64[n], pid: pid[n], tid: tid[n]};
                acc[n]  = vld[n] && (q[n].size() < DEPTH) && !flush[n];
                cand[n] = (q[n].size() > 0) && !flush[n];
            end
            if (stall && mEn) mStall = sat(mStall);
            if (!stall) begin
                mEn = cand[0] || cand[1];
                if (mEn) begin
                    if (cand[0] && cand[1]) w = mLast ? 0 : 1;
                    else                    w = cand[1] ? 1 : 0;
                    mOut  = q[w].pop_front();
                    mMaj  = mCnt;
                    mThr  = w[0];
                    mCnt  = mCnt + 1;
                    mLast = w[0];
                    mIss[w] = sat(mIss[w]);
                end
            end else if (flush[mThr]) begin
                mEn = 0;
            end
            for (int n = 0; n < 2; n++) begin
                if (flush[n]) q[n].delete();
                if (acc[n])   q[n].push_back(inE[n]);
            end
        end
    end

    // Every-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (chkOn) begin
            chk("t0Ready", t0Ready, q[0].size() < DEPTH);
            chk("t1Ready", t1Ready, q[1].size() < DEPTH);
            chk("decEnable", decEnable, mEn);
            chk("payload", {decInstruction, decAddress, decIs64Bit, decPid, decTid, decMajId, decThread},
                           {mOut.ins, mOut.addr, mOut.is64, mOut.pid, mOut.tid, mMaj, mThr});
`ifdef DECODE_SCHED_PERF_EN
            chk("perf", {t0IssueCount, t1IssueCount, stallCycles}, {mIss[0], mIss[1], mStall});
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        vld[0] = 0; vld[1] = 0; flush = 2'b00;
    endtask

    task automatic setPush(input int n, input logic [31:0] i, input logic [63:0] a);
        vld[n] = 1; ins[n] = i; addr[n] = a;
        is64[n] = $urandom_range(0, 1); pid[n] = 20'($urandom); tid[n] = 16'($urandom);
    endtask

    task automatic doReset();
        idle(); stall = 0; rst = 1;
        tick(); chkOn = 1; tick();
        rst = 0;
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin
            ins[n] = '0; addr[n] = '0; is64[n] = 0; pid[n] = '0; tid[n] = '0;
        end
        idle(); stall = 0; rst = 1;
        tick();

        // Reset state
        doReset();
        chk("rst_enable", decEnable, 0);
        chk("rst_ready", {t0Ready, t1Ready}, 2'b11);
        chk("rst_majId", decMajId, 0);
        chk("rst_ins", decInstruction, 0);

        // Single push on thread 0, one cycle FIFO-to-output latency
        setPush(0, 32'h7C22_1A14, 64'h100);
        tick(); idle();
        chk("t1_no_bypass", decEnable, 0);
        tick();
        chk("t1_enable", decEnable, 1);
        chk("t1_majId", decMajId, 0);
        chk("t1_thread", decThread, 0);
        chk("t1_ins", decInstruction, 32'h7C22_1A14);
        chk("t1_addr", decAddress, 64'h100);
        tick();

        // Interleaved issue from two filled FIFOs
        doReset();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            setPush(0, 32'hA000 + i, 64'h1000 + 4 * i);
            setPush(1, 32'hB000 + i, 64'h2000 + 4 * i);
            tick();
        end
        idle(); stall = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_thread", decThread, i % 2);
            chk("rr_majId", decMajId, i);
            chk("rr_ins", decInstruction, (i % 2) ? 32'hB000 + i / 2 : 32'hA000 + i / 2);
        end
        tick();
        chk("rr_drained", decEnable, 0);

        // Full FIFO on thread 1, fifth push dropped
        doReset();
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            setPush(1, 32'h1000 + i, 64'h40 * i);
            tick();
            if (i >= 3) chk("full_ready", t1Ready, 0);
        end
        idle(); stall = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full_thread", decThread, 1);
            chk("full_majId", decMajId, i);
            chk("full_ins", decInstruction, 32'h1000 + i);
        end
        tick();
        chk("full_drained", decEnable, 0);

        // Stall holds a valid output for five cycles
        doReset();
        setPush(0, 32'hCAFE_0001, 64'h500);
        tick(); idle(); tick();
        stall = 1;
        setPush(0, 32'hCAFE_0002, 64'h504);
        for (int i = 0; i < 5; i++) begin
            tick(); idle();
            chk("stall_hold", {decEnable, decInstruction, decMajId}, {1'b1, 32'hCAFE_0001, 64'd0});
        end
`ifdef DECODE_SCHED_PERF_EN
        chk("stall_cycles", stallCycles, 5);
`endif
        stall = 0;
        tick();
        chk("stall_release", {decEnable, decInstruction, decMajId}, {1'b1, 32'hCAFE_0002, 64'd1});
        tick();

        // Flush of the stalled thread
        doReset();
        setPush(0, 32'hF000, 64'h0);
        tick();
        setPush(0, 32'hF001, 64'h4);
        tick();
        stall = 1;
        setPush(0, 32'hF002, 64'h8);
        setPush(1, 32'hE000, 64'h800);
        tick(); idle();
        setPush(0, 32'hF003, 64'hC);
        tick(); idle();
        chk("flush_pre", {decEnable, decInstruction}, {1'b1, 32'hF000});
        flush = 2'b01;
        tick(); idle();
        chk("flush_enable", decEnable, 0);
        stall = 0;
        tick();
        chk("flush_t1", {decEnable, decThread, decMajId, decInstruction}, {1'b1, 1'b1, 64'd1, 32'hE000});
        tick();
        chk("flush_empty", decEnable, 0);

        // Major ID wrap
        doReset();
        force dut.majCounter = 64'hFFFF_FFFF_FFFF_FFFF;
        mCnt = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.majCounter;
        setPush(0, 32'h1111, 64'h10);
        tick();
        setPush(0, 32'h2222, 64'h14);
        tick(); idle();
        chk("wrap_hi", decMajId, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("wrap_lo", decMajId, 0);
        tick();

        // Randomized traffic
        doReset();
        for (int c = 0; c < 4000; c++) begin
            for (int n = 0; n < 2; n++) begin
                vld[n] = ($urandom_range(0, 3) != 0);
                ins[n] = $urandom; addr[n] = {$urandom, $urandom};
                is64[n] = $urandom_range(0, 1); pid[n] = 20'($urandom); tid[n] = 16'($urandom);
            end
            stall = ($urandom_range(0, 9) < 3);
            flush = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        idle(); stall = 0; rst = 0;
        for (int i = 0; i < 12; i++) tick();
        chk("rand_drained", {decEnable, t0Ready, t1Ready}, 3'b011);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
